branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/branch_predictor_sat_counter.sv | 26 ++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types and constants for the branch predictor.
//   bp_entry_t         : one predictor table entry (valid, tag, target, counter).
//                        Tag and counter fields are sized for the widest legal
//                        configuration (ENTRIES=4, CNT_W=4); narrower builds
//                        zero-extend into them.
//   bp_cnt_weak_taken  : counter value with MSB=1, lower bits 0.
//   bp_cnt_weak_ntaken : counter value with MSB=0, lower bits 1.
package cpu_types_pkg;

  localparam int BP_TAG_W_MAX = 28;
  localparam int BP_CNT_W_MAX = 4;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_W_MAX-1:0] tag;
    logic [31:0]             target;
    logic [BP_CNT_W_MAX-1:0] cnt;
  } bp_entry_t;

  function automatic logic [BP_CNT_W_MAX-1:0] bp_cnt_weak_taken(input int w);
    return BP_CNT_W_MAX'(1) << (w - 1);
  endfunction

  function automatic logic [BP_CNT_W_MAX-1:0] bp_cnt_weak_ntaken(input int w);
    return (BP_CNT_W_MAX'(1) << (w - 1)) - BP_CNT_W_MAX'(1);
  endfunction

  // Values for the default 2-bit counter.
  localparam logic [BP_CNT_W_MAX-1:0] BP_CNT2_WT  = bp_cnt_weak_taken(2);
  localparam logic [BP_CNT_W_MAX-1:0] BP_CNT2_WNT = bp_cnt_weak_ntaken(2);

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// sat_counter -- next-state logic for one saturating counter.
//   i_cnt : current counter value
//   inc   : 1 = count up, 0 = count down
//   en    : apply the step; otherwise o_cnt = i_cnt
//   o_cnt : next counter value, clamped at 0 and 2^CNT_W-1
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             inc,
  input  logic             en,
  output logic [CNT_W-1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (en) begin
      if (inc) begin
        if (i_cnt != '1) o_cnt = i_cnt + CNT_W'(1);
      end else begin
        if (i_cnt != '0) o_cnt = i_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped BTB with per-entry saturating counters.
//   CLK, RST          : clock, synchronous active-high reset
//   lookup_pc         : IF-stage fetch PC; lookup is combinational
//   pred_hit/taken    : valid tag match / match with counter MSB set
//   pred_target       : stored target, 0 on a miss
//   upd_*             : EX-stage resolved branch, written at the rising edge
//   stat_updates, stat_mispredicts : present only with BP_STATS_EN defined
// Optional feature macro: BP_STATS_EN.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [BP_CNT_W_MAX-1:0] CNT_WT  = bp_cnt_weak_taken(CNT_W);
  localparam logic [BP_CNT_W_MAX-1:0] CNT_WNT = bp_cnt_weak_ntaken(CNT_W);

  logic [IDX_W-1:0]        w_lk_idx, w_up_idx;
  logic [BP_TAG_W_MAX-1:0] w_lk_tag, w_up_tag;
  bp_entry_t [ENTRIES-1:0] w_tbl;
  bp_entry_t               w_lk_ent, w_up_ent;
  logic                    w_lk_hit, w_up_hit;

  // Tags are zero-extended into the fixed-width struct field.
  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_lk_tag = BP_TAG_W_MAX'(lookup_pc[31:IDX_W+2]);
  assign w_up_tag = BP_TAG_W_MAX'(upd_pc[31:IDX_W+2]);

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign w_lk_ent = w_tbl[w_lk_idx];
  assign w_up_ent = w_tbl[w_up_idx];
  assign w_lk_hit = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
  assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

  assign pred_hit    = w_lk_hit;
  assign pred_taken  = w_lk_hit && w_lk_ent.cnt[CNT_W-1];
  assign pred_target = w_lk_hit ? w_lk_ent.target : 32'h0;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bp_entry_t        r_ent;
    logic             w_sel;
    logic [CNT_W-1:0] w_cnt_cur, w_cnt_nxt;

    assign w_sel     = upd_valid && (w_up_idx == IDX_W'(g));
    assign w_cnt_cur = CNT_W'(r_ent.cnt);

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_cnt (w_cnt_cur),
      .inc   (upd_taken),
      .en    (w_sel && w_up_hit),
      .o_cnt (w_cnt_nxt)
    );

    // Tag and target are left untouched by reset; valid=0 masks them.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_ent.valid <= 1'b0;
        r_ent.cnt   <= CNT_WNT;
      end else if (w_sel) begin
        if (w_up_hit) begin
          r_ent.cnt <= BP_CNT_W_MAX'(w_cnt_nxt);
          if (upd_taken) r_ent.target <= upd_target;
        end else if (upd_taken) begin
          r_ent.valid  <= 1'b1;
          r_ent.tag    <= w_up_tag;
          r_ent.target <= upd_target;
          r_ent.cnt    <= CNT_WT;
        end
      end
    end

    assign w_tbl[g] = r_ent;
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_upd, r_stat_mis;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (upd_valid) begin
      r_stat_upd <= r_stat_upd + 32'd1;
      if (upd_mispredict) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_updates     = r_stat_upd;
  assign stat_mispredicts = r_stat_mis;

  logic w_unused;
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0], w_lk_ent, w_up_ent};
`else
  logic w_unused;
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0], w_lk_ent, w_up_ent, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CHALF   = 1 << (CNT_W - 1);

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts;
`endif

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by (pc/4) mod ENTRIES.
  bit          m_valid[ENTRIES];
  int unsigned m_tag  [ENTRIES];
  logic [31:0] m_tgt  [ENTRIES];
  int          m_cnt  [ENTRIES];
  int unsigned m_upd, m_mis;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[idx_of(pc)] >= CHALF);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
  endfunction

  // Applies what the rising edge does to the current inputs.
  function automatic void model_edge();
    int unsigned i;
    if (RST) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = CHALF - 1;
      end
      m_upd = 0;
      m_mis = 0;
    end else if (upd_valid) begin
      m_upd++;
      if (upd_mispredict) m_mis++;
      i = idx_of(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upd_pc);
        m_tgt[i]   = upd_target;
        m_cnt[i]   = CHALF;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input logic [31:0] lk, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit um);
    RST            = rst;
    lookup_pc      = lk;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = um;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned t;
    t = ($urandom_range(0, 7) == 0) ? 32'h3FF_FFFF : $urandom_range(0, 3);
    return (t * ENTRIES * 4) + ($urandom_range(0, ENTRIES - 1) * 4) + $urandom_range(0, 3);
  endfunction

  typedef struct {
    string       nm;
    bit          rst;
    logic [31:0] lk;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    bit          chk;
    bit          eh;
    bit          et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input bit rst, input logic [31:0] lk,
                              input bit uv, input logic [31:0] upc, input bit ut,
                              input logic [31:0] utgt, input bit c, input bit eh,
                              input bit et, input logic [31:0] etgt);
    vec_t v;
    v.nm = nm; v.rst = rst; v.lk = lk; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.chk = c; v.eh = eh; v.et = et; v.etgt = etgt;
    vecs.push_back(v);
  endfunction

  initial begin
    //   name           rst lookup        uv upd_pc        t  target        chk hit tk target
    add("reset",         1, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0);
    add("post_reset",    0, 32'h0000_0040, 1, 32'h40,       1, 32'h100,      1, 0, 0, 32'h0);
    add("alloc",         0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h100);
    add("inc_a",         0, 32'h0000_0040, 1, 32'h40,       1, 32'h100,      1, 1, 1, 32'h100);
    add("inc_b",         0, 32'h0000_0040, 1, 32'h40,       1, 32'h100,      1, 1, 1, 32'h100);
    add("inc_sat",       0, 32'h0000_0040, 1, 32'h40,       1, 32'h100,      1, 1, 1, 32'h100);
    add("dec_a",         0, 32'h0000_0040, 1, 32'h40,       0, 32'h999,      1, 1, 1, 32'h100);
    add("dec_b",         0, 32'h0000_0040, 1, 32'h40,       0, 32'h999,      1, 1, 1, 32'h100);
    add("cnt_01",        0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h100);
    add("dec_c",         0, 32'h0000_0040, 1, 32'h40,       0, 32'h0,        1, 1, 0, 32'h100);
    add("dec_sat0",      0, 32'h0000_0040, 1, 32'h40,       0, 32'h0,        1, 1, 0, 32'h100);
    add("tk_from0",      0, 32'h0000_0040, 1, 32'h40,       1, 32'h200,      1, 1, 0, 32'h100);
    add("tgt_upd",       0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h200);
    add("alias_wr",      0, 32'h0000_0040, 1, 32'h440,      1, 32'h300,      1, 1, 0, 32'h200);
    add("alias_old",     0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0);
    add("alias_new",     0, 32'h0000_0440, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h300);
    add("same_cyc",      0, 32'h0000_0080, 1, 32'h80,       1, 32'h500,      1, 0, 0, 32'h0);
    add("same_nxt",      0, 32'h0000_0080, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h500);
    add("miss_nt",       0, 32'h0000_0080, 1, 32'hC0,       0, 32'h600,      1, 1, 1, 32'h500);
    add("miss_nt_keep",  0, 32'h0000_0080, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h500);
    add("miss_nt_noal",  0, 32'h0000_00C0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0);
    add("rst_upd",       1, 32'h0000_0080, 1, 32'h1004,     1, 32'h700,      0, 0, 0, 32'h0);
    add("rst_clr",       0, 32'h0000_0080, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0);
    add("rst_disc",      0, 32'h0000_1004, 1, 32'h203,      1, 32'h800,      1, 0, 0, 32'h0);
    add("lowbits_a",     0, 32'h0000_0200, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h800);
    add("lowbits_b",     0, 32'h0000_0201, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h800);

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].lk, vecs[n].uv, vecs[n].upc, vecs[n].ut, vecs[n].utgt, 1'b0);
      @(negedge CLK);
      if (vecs[n].chk) begin
        chk({vecs[n].nm, ".hit"},    32'(pred_hit),   32'(vecs[n].eh));
        chk({vecs[n].nm, ".taken"},  32'(pred_taken), 32'(vecs[n].et));
        chk({vecs[n].nm, ".target"}, pred_target,     vecs[n].etgt);
      end
      advance();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) == 0, rand_pc(), $urandom_range(0, 1) == 1, rand_pc(),
            $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0);
      @(negedge CLK);
      chk("rnd.hit",    32'(pred_hit),   32'(m_hit(lookup_pc)));
      chk("rnd.taken",  32'(pred_taken), 32'(m_taken(lookup_pc)));
      chk("rnd.target", pred_target,     m_target(lookup_pc));
`ifdef BP_STATS_EN
      chk("rnd.stat_upd", stat_updates,     m_upd);
      chk("rnd.stat_mis", stat_mispredicts, m_mis);
`endif
      advance();
    end

`ifdef BP_STATS_EN
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 32'h1000 + 32'(k * 4), 1, 32'h2000, (k == 0) || (k == 2));
      @(negedge CLK);
      advance();
    end
    drive(0, 32'h3000, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("stat.upd5", stat_updates,     32'd5);
    chk("stat.mis2", stat_mispredicts, 32'd2);
    advance();
    drive(1, 32'h3000, 1, 32'h3000, 1, 32'h4000, 1);
    @(negedge CLK);
    advance();
    drive(0, 32'h3000, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("stat.upd_rst", stat_updates,     32'd0);
    chk("stat.mis_rst", stat_mispredicts, 32'd0);
    chk("stat.rst_hit", 32'(pred_hit),    32'd0);
    advance();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
